// File: rtl/bp_pkg.sv
// Shared constants for the branch predictor: counter encodings, instruction size
// and BTB entry field widths derived from the index width.
package bp_pkg;

    localparam logic [1:0] CTR_SNT   = 2'b00;
    localparam logic [1:0] CTR_WNT   = 2'b01;
    localparam logic [1:0] CTR_WT    = 2'b10;
    localparam logic [1:0] CTR_ST    = 2'b11;
    localparam logic [1:0] CTR_RESET = CTR_WNT;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    localparam int TARGET_W = 30;
    localparam int CTR_W    = 2;

    function automatic int tag_w(input int idx_w);
        return 30 - idx_w;
    endfunction

    function automatic int entry_w(input int idx_w);
        return 1 + tag_w(idx_w) + TARGET_W + CTR_W;
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// Combinational next-state for a 2-bit saturating direction counter.
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       inc,
    output logic [1:0] ctr_next
);

    always_comb begin
        // NOTE: default first so no path through the block leaves ctr_next unassigned (no latch).
        ctr_next = ctr;
        if (inc) begin
            if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational fetch-time prediction,
// execute-time misprediction detection and synchronous table/statistics update.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc,
    output logic        br_pred,
    output logic [31:0] new_pc_pred,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        miss_pred,
    output logic [31:0] new_pc,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_misses
);

    localparam int TAG_W = tag_w(IDX_W);

    typedef struct packed {
        logic                valid;
        logic [TAG_W-1:0]    tag;
        logic [TARGET_W-1:0] target;
        logic [CTR_W-1:0]    ctr;
    } btb_entry_t;

    btb_entry_t btb_q [ENTRIES];
    btb_entry_t wr_entry_d;
    logic       wr_en_d;

    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_misses_q,   stat_misses_d;

    logic [IDX_W-1:0] fe_idx, ex_idx;
    logic [TAG_W-1:0] fe_tag, ex_tag;
    logic             fe_hit, ex_hit;
    logic [1:0]       ctr_next;
    logic             unused_pc_bits;

    assign fe_idx = pc[IDX_W+1:2];
    assign fe_tag = pc[31:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[31:IDX_W+2];
    assign unused_pc_bits = ^pc[1:0];

    // Lookup reads registered state only, so a same-index update is seen next cycle.
    assign fe_hit      = btb_q[fe_idx].valid && (btb_q[fe_idx].tag == fe_tag);
    assign br_pred     = fe_hit && btb_q[fe_idx].ctr[1];
    assign new_pc_pred = fe_hit ? {btb_q[fe_idx].target, 2'b00} : 32'd0;

    assign ex_hit = btb_q[ex_idx].valid && (btb_q[ex_idx].tag == ex_tag);

    always_comb begin
        miss_pred = 1'b0;
        if (ex_valid) begin
            if (ex_is_branch)
                miss_pred = (ex_taken != ex_pred_taken) ||
                            (ex_taken && ex_pred_taken && (ex_pred_target != ex_target));
            else
                miss_pred = ex_pred_taken;
        end
    end

    assign new_pc = ex_taken ? ex_target : ex_pc + INSTR_BYTES;

    sat_counter2 u_sat_counter2 (
        .ctr      (btb_q[ex_idx].ctr),
        .inc      (ex_taken),
        .ctr_next (ctr_next)
    );

    always_comb begin
        wr_en_d    = 1'b0;
        wr_entry_d = btb_q[ex_idx];
        if (ex_valid) begin
            if (ex_is_branch) begin
                if (ex_hit) begin
                    wr_en_d        = 1'b1;
                    wr_entry_d.ctr = ctr_next;
                    if (ex_taken) wr_entry_d.target = ex_target[31:2];
                end else if (ex_taken) begin
                    wr_en_d           = 1'b1;
                    wr_entry_d.valid  = 1'b1;
                    wr_entry_d.tag    = ex_tag;
                    wr_entry_d.target = ex_target[31:2];
                    wr_entry_d.ctr    = CTR_WT;
                end
            end else if (ex_hit) begin
                wr_en_d          = 1'b1;
                wr_entry_d.valid = 1'b0;
            end
        end
    end

    always_comb begin
        stat_branches_d = stat_branches_q;
        stat_misses_d   = stat_misses_q;
        if (ex_valid && ex_is_branch && (stat_branches_q != 32'hFFFF_FFFF))
            stat_branches_d = stat_branches_q + 32'd1;
        if (miss_pred && (stat_misses_q != 32'hFFFF_FFFF))
            stat_misses_d = stat_misses_q + 32'd1;
    end

    // NOTE: the table is a small register array, so every entry is reset; a RAM-backed
    // table would instead need a valid-bit clear sweep.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};
            end
            stat_branches_q <= 32'd0;
            stat_misses_q   <= 32'd0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            if (wr_en_d) btb_q[ex_idx] <= wr_entry_d;
            stat_branches_q <= stat_branches_d;
            stat_misses_q   <= stat_misses_d;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_misses   = stat_misses_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc;
    logic        br_pred;
    logic [31:0] new_pc_pred;
    logic        ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        miss_pred;
    logic [31:0] new_pc, stat_branches, stat_misses;

    int tests_run = 0;
    int tests_failed = 0;

    branch_predictor #(.ENTRIES(16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pc             (pc),
        .br_pred        (br_pred),
        .new_pc_pred    (new_pc_pred),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .miss_pred      (miss_pred),
        .new_pc         (new_pc),
        .stat_branches  (stat_branches),
        .stat_misses    (stat_misses)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_idle();
        ex_valid = 1'b0; ex_is_branch = 1'b0; ex_pc = '0; ex_taken = 1'b0;
        ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
    endtask

    task automatic ex_drive(input logic br, input logic [31:0] epc, input logic tk,
                            input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        ex_valid = 1'b1; ex_is_branch = br; ex_pc = epc; ex_taken = tk;
        ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
        #1;
    endtask

    task automatic lookup(input string tag, input logic [31:0] a,
                          input logic exp_pred, input logic [31:0] exp_tgt);
        pc = a;
        #1;
        check({tag, "_br_pred"}, {31'd0, br_pred}, {31'd0, exp_pred});
        check({tag, "_new_pc_pred"}, new_pc_pred, exp_tgt);
    endtask

    initial begin
        reset_n = 1'b0;
        pc = 32'h100;
        ex_idle();
        #2;
        check("rst_br_pred", {31'd0, br_pred}, 32'd0);
        check("rst_new_pc_pred", new_pc_pred, 32'd0);
        check("rst_stat_br", stat_branches, 32'd0);
        check("rst_stat_miss", stat_misses, 32'd0);
        step();
        reset_n = 1'b1;
        step();

        // Allocate 0x100 -> 0x200 (ctr 10)
        ex_drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        check("alloc_miss", {31'd0, miss_pred}, 32'd1);
        check("alloc_new_pc", new_pc, 32'h200);
        check("alloc_rbw_br_pred", {31'd0, br_pred}, 32'd0);
        step(); ex_idle();
        lookup("after_alloc", 32'h100, 1'b1, 32'h200);
        check("after_alloc_stat_miss", stat_misses, 32'd1);
        check("after_alloc_stat_br", stat_branches, 32'd1);

        // Not taken twice: 10 -> 01 -> 00
        ex_drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
        check("nt1_miss", {31'd0, miss_pred}, 32'd1);
        check("nt1_new_pc", new_pc, 32'h104);
        step(); ex_idle();
        lookup("nt1", 32'h100, 1'b0, 32'h200);
        ex_drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        check("nt2_miss", {31'd0, miss_pred}, 32'd0);
        step(); ex_idle();
        lookup("nt2", 32'h100, 1'b0, 32'h200);

        // Taken twice: 00 -> 01 -> 10
        ex_drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        step(); ex_idle();
        lookup("t1", 32'h100, 1'b0, 32'h200);
        ex_drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        check("t2_rbw_br_pred", {31'd0, br_pred}, 32'd0);
        step(); ex_idle();
        lookup("t2", 32'h100, 1'b1, 32'h200);
        check("t2_stat_br", stat_branches, 32'd5);
        check("t2_stat_miss", stat_misses, 32'd4);

        // Wrong target: 10 -> 11, target becomes 0x300
        ex_drive(1'b1, 32'h100, 1'b1, 32'h300, 1'b1, 32'h200);
        check("wt_miss", {31'd0, miss_pred}, 32'd1);
        check("wt_new_pc", new_pc, 32'h300);
        step(); ex_idle();
        lookup("wt", 32'h100, 1'b1, 32'h300);
        // Correct prediction at 11 (saturates), then one not-taken -> 10
        ex_drive(1'b1, 32'h100, 1'b1, 32'h300, 1'b1, 32'h300);
        check("ok_miss", {31'd0, miss_pred}, 32'd0);
        step();
        ex_drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h300);
        step(); ex_idle();
        lookup("sat_hi", 32'h100, 1'b1, 32'h300);
        check("sat_stat_br", stat_branches, 32'd8);
        check("sat_stat_miss", stat_misses, 32'd6);

        // Aliasing: 0x140 evicts 0x100
        ex_drive(1'b1, 32'h140, 1'b1, 32'h180, 1'b0, 32'h0);
        step(); ex_idle();
        lookup("evicted", 32'h100, 1'b0, 32'h0);
        lookup("alias_hit", 32'h140, 1'b1, 32'h180);
        ex_drive(1'b0, 32'h140, 1'b0, 32'h0, 1'b1, 32'h180);
        check("alias_miss", {31'd0, miss_pred}, 32'd1);
        check("alias_new_pc", new_pc, 32'h144);
        step(); ex_idle();
        lookup("alias_inval", 32'h140, 1'b0, 32'h0);
        check("alias_stat_br", stat_branches, 32'd9);
        check("alias_stat_miss", stat_misses, 32'd8);
        ex_pred_taken = 1'b1; ex_is_branch = 1'b0;
        #1;
        check("novalid_miss", {31'd0, miss_pred}, 32'd0);
        ex_idle();

        // Wrap-around of ex_pc + 4
        ex_drive(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h40);
        check("wrap_miss", {31'd0, miss_pred}, 32'd1);
        check("wrap_new_pc", new_pc, 32'h0);
        step(); ex_idle();
        lookup("wrap_noalloc", 32'hFFFF_FFFC, 1'b0, 32'h0);
        check("wrap_stat_br", stat_branches, 32'd10);
        check("wrap_stat_miss", stat_misses, 32'd9);

        // Reset asserted between edges while an allocating update is pending
        ex_drive(1'b1, 32'h200, 1'b1, 32'h400, 1'b0, 32'h0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_stat_br", stat_branches, 32'd0);
        check("mid_rst_stat_miss", stat_misses, 32'd0);
        check("mid_rst_miss_comb", {31'd0, miss_pred}, 32'd1);
        lookup("mid_rst", 32'h200, 1'b0, 32'h0);
        step();
        ex_idle();
        reset_n = 1'b1;
        step();
        lookup("post_rst", 32'h200, 1'b0, 32'h0);
        check("post_rst_stat_br", stat_branches, 32'd0);
        check("post_rst_stat_miss", stat_misses, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
